// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/response bus for the dmem_ctrl data memory
//
// Purpose : groups the MEM-stage request and response signals of dmem_ctrl.
// Signals :
//   req_valid    master->slave  access request this cycle
//   req_write    master->slave  1 = store, 0 = load
//   funct3       master->slave  RV32I load/store funct3 (size/sign)
//   addr         master->slave  byte address, ADDR_W bits
//   wdata        master->slave  store data, right-justified
//   busy         slave->master  memory not accepting requests
//   rsp_valid    slave->master  response for the request accepted last cycle
//   rdata        slave->master  extended load result
//   misalign_err slave->master  address misaligned for the access size
//   access_err   slave->master  out-of-range address or illegal funct3
// Modports: master (pipeline side), slave (memory side).

interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_write;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              rsp_valid;
  logic [31:0]       rdata;
  logic              misalign_err;
  logic              access_err;

  modport master (
    output req_valid, req_write, funct3, addr, wdata,
    input  busy, rsp_valid, rdata, misalign_err, access_err
  );

  modport slave (
    input  req_valid, req_write, funct3, addr, wdata,
    output busy, rsp_valid, rdata, misalign_err, access_err
  );

endinterface

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32 byte/half/word data memory with registered read path
//
// Purpose : MEM-stage data memory. Byte, half and word loads/stores with
//           sign/zero extension chosen by funct3, a one-cycle registered
//           response, misalignment / range / illegal-size detection and an
//           optional post-reset sweep that zeroes the whole array.
// Build option:
//   DMEM_CLEAR_EN  defined   -> reset enters CLEAR, busy for DEPTH cycles while
//                               every word is written with zero
//                  undefined -> reset enters INIT, busy for one cycle, memory
//                               contents survive reset
// Parameters:
//   DEPTH   number of 32-bit words (power of two, >= 4)
//   ADDR_W  byte address width (must match the interface, > IDX_W+1)
//   IDX_W   derived word index width
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   bus     dmem_ctrl_if slave modport (request in, response out)

module dmem_ctrl #(
  parameter  int DEPTH  = 256,
  parameter  int ADDR_W = 32,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  dmem_ctrl_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
`ifdef DMEM_CLEAR_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1
  } state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;
  logic   w_busy;

`ifdef DMEM_CLEAR_EN
  logic [IDX_W-1:0] r_clr_cnt;
  logic             w_clr_last;
  logic             w_clr_we;

  assign w_clr_last = (r_clr_cnt == IDX_W'(DEPTH - 1));
  // The reset edge itself must not touch the array, so the sweep write is
  // suppressed while rst is high even if the FSM is already in CLEAR.
  assign w_clr_we   = (r_state == ST_CLEAR) && !rst;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DMEM_CLEAR_EN
      r_state <= ST_CLEAR;
`else
      r_state <= ST_INIT;
`endif
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    case (r_state)
`ifdef DMEM_CLEAR_EN
      ST_CLEAR: begin
        if (w_clr_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      ST_INIT: begin
        w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        w_busy = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifdef DMEM_CLEAR_EN
  // Counter is held at zero outside CLEAR, so a reset mid-sweep restarts at
  // word 0.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_CLEAR)) begin
      r_clr_cnt <= '0;
    end else begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end
`endif

  assign bus.busy = w_busy;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [2:0]       w_f3;
  logic             w_is_byte;
  logic             w_is_half;
  logic             w_is_word;
  logic             w_f3_bad;
  logic             w_oob;
  logic             w_mis;
  logic             w_acc_err;
  logic             w_accept;
  logic             w_store;
  logic             w_load;
  logic [IDX_W-1:0] w_idx;

  assign w_f3      = bus.funct3;
  // 000/100 are byte, 001/101 are half, 010 is word; the unsigned encodings
  // are only meaningful for loads.
  assign w_is_byte = (w_f3[1:0] == 2'b00);
  assign w_is_half = (w_f3[1:0] == 2'b01);
  assign w_is_word = (w_f3 == 3'b010);
  assign w_f3_bad  = (w_f3[1] & w_f3[0])            // 011, 111
                   | (w_f3[2] & w_f3[1])            // 110, 111
                   | (w_f3[2] & bus.req_write);     // SBU/SHU do not exist

  // Misalignment is judged only for the sizes that have an alignment rule;
  // illegal-size encodings are reported through access_err alone.
  assign w_mis     = (w_is_half & bus.addr[0])
                   | (w_is_word & (bus.addr[1:0] != 2'b00));
  assign w_oob     = (bus.addr >= ADDR_W'(DEPTH * 4));
  assign w_acc_err = w_oob | w_f3_bad;

  assign w_accept  = bus.req_valid & ~w_busy & ~rst;
  assign w_store   = w_accept &  bus.req_write & ~w_mis & ~w_acc_err;
  assign w_load    = w_accept & ~bus.req_write;
  assign w_idx     = bus.addr[IDX_W+1:2];

  // --------------------------------------------------------------------------
  // Store lane steering: the data is replicated across lanes so each enabled
  // byte simply picks its own lane; no read-modify-write is needed.
  // --------------------------------------------------------------------------
  logic [3:0]  w_be;
  logic [31:0] w_wlane;

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = bus.wdata;
    if (w_is_byte) begin
      w_be    = 4'b0001 << bus.addr[1:0];
      w_wlane = {4{bus.wdata[7:0]}};
    end else if (w_is_half) begin
      w_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
      w_wlane = {2{bus.wdata[15:0]}};
    end else if (w_is_word) begin
      w_be    = 4'b1111;
    end
  end

  // --------------------------------------------------------------------------
  // Storage array and synchronous read
  // --------------------------------------------------------------------------
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rword;

  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end
`endif
    for (int b = 0; b < 4; b++) begin
      if (w_store && w_be[b]) begin
        r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
    // Only one request is accepted per cycle, so a load never races a store
    // on this edge; a store on the previous edge is already visible here.
    if (w_load) begin
      r_rword <= r_mem[w_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Response registers
  // --------------------------------------------------------------------------
  logic       r_rsp_valid;
  logic       r_mis;
  logic       r_acc;
  logic       r_ld_ok;
  logic [1:0] r_off;
  logic [2:0] r_f3;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_mis       <= 1'b0;
      r_acc       <= 1'b0;
      r_ld_ok     <= 1'b0;
      r_off       <= 2'b00;
      r_f3        <= 3'b000;
    end else begin
      r_rsp_valid <= w_accept;
      r_mis       <= w_accept & w_mis;
      r_acc       <= w_accept & w_acc_err;
      r_ld_ok     <= w_load & ~w_mis & ~w_acc_err;
      r_off       <= bus.addr[1:0];
      r_f3        <= w_f3;
    end
  end

  // --------------------------------------------------------------------------
  // Load extraction and extension (little-endian)
  // --------------------------------------------------------------------------
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_ext;

  always_comb begin
    w_ld_byte = r_rword[{r_off, 3'b000} +: 8];
    w_ld_half = r_off[1] ? r_rword[31:16] : r_rword[15:0];
    case (r_f3)
      3'b000:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_ext = {24'h000000, w_ld_byte};
      3'b001:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_ext = {16'h0000, w_ld_half};
      default: w_ld_ext = r_rword;
    endcase
  end

  // rdata is forced to zero for stores, errored accesses and idle cycles, which
  // also hides the uninitialised read register after power-up.
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rdata        = r_ld_ok ? w_ld_ext : 32'h0000_0000;
  assign bus.misalign_err = r_mis;
  assign bus.access_err   = r_acc;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl against a byte-array model
//
// Purpose : drives directed and random requests through dmem_ctrl_if and
//           compares every response with a byte-addressed reference model.
//           Works with DMEM_CLEAR_EN defined or undefined.

module tb_dmem_ctrl;

  localparam int DEPTH  = 256;
  localparam int NBYTES = DEPTH * 4;
`ifdef DMEM_CLEAR_EN
  localparam int BUSY_CYC = DEPTH;
  localparam bit CLR      = 1'b1;
`else
  localparam int BUSY_CYC = 1;
  localparam bit CLR      = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_W(32)) bus ();

  dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         nvec  = 0;
  int         nfail = 0;
  logic [7:0] mem_m [NBYTES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
  endtask

  // Reference behaviour from the access rules: size from funct3, range and
  // alignment checks, then byte-wise little-endian update or gather.
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output bit mis, output bit acc);
    int          n;
    logic [31:0] raw;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    acc = (a >= NBYTES) || (n == 0) || (w && f3[2]);
    mis = ((n == 2) && (a % 2 != 0)) || ((n == 4) && (a % 4 != 0));
    rd  = 32'h0;
    if (acc || mis) return;
    if (w) begin
      for (int i = 0; i < n; i++) mem_m[a + i] = 8'(wd >> (8 * i));
    end else begin
      raw = 32'h0;
      for (int i = 0; i < n; i++) raw = raw | (32'(mem_m[a + i]) << (8 * i));
      if (!f3[2] && (n < 4) && raw[8 * n - 1]) raw = raw | ~((32'h1 << (8 * n)) - 32'h1);
      rd = raw;
    end
  endtask

  // Presents one request (or an idle cycle), advances one clock and checks the
  // response that must appear exactly one cycle after the accept.
  task automatic step(input bit v, input bit w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic [31:0] erd;
    bit          emis;
    bit          eacc;
    erd = 32'h0; emis = 1'b0; eacc = 1'b0;
    bus.req_valid = v;
    bus.req_write = w;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
    if (v) model(w, f3, a, wd, erd, emis, eacc);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(v));
    if (v) begin
      chk({tag, ".rdata"}, bus.rdata, erd);
      chk({tag, ".misalign_err"}, 32'(bus.misalign_err), 32'(emis));
      chk({tag, ".access_err"}, 32'(bus.access_err), 32'(eacc));
    end
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, ".rdata"}, bus.rdata, 32'h0);
    chk({tag, ".misalign_err"}, 32'(bus.misalign_err), 32'h0);
    chk({tag, ".access_err"}, 32'(bus.access_err), 32'h0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'h1);
  endtask

  // Counts busy cycles after reset release; optionally holds a store to word
  // 0x14 on the bus the whole time, which must be dropped.
  task automatic wait_idle(input int exp, input bit poke, input string tag);
    int n;
    n = 0;
    if (poke) begin
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.funct3    = 3'b010;
      bus.addr      = 32'h14;
      bus.wdata     = 32'hDEAD_BEEF;
    end
    while (bus.busy === 1'b1 && n < 4 * DEPTH + 16) begin
      @(posedge clk); #1;
      n++;
      chk({tag, ".no_rsp_while_busy"}, 32'(bus.rsp_valid), 32'h0);
    end
    bus.req_valid = 1'b0;
    chk({tag, ".busy_cycles"}, 32'(n), 32'(exp));
  endtask

  initial begin
    logic [2:0]  f3_tab [14];
    logic [2:0]  f3;
    logic [31:0] a;
    bit          v;
    bit          w;
    int          r;

    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5,
               3'd2, 3'd3, 3'd6, 3'd7};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.funct3    = 3'b000;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset and busy window; in the sweep build, restart it at cycle 100.
    apply_reset("rst1");
    if (CLR) begin
      for (int i = 0; i < 99; i++) begin
        @(posedge clk); #1;
        chk("sweep.busy", 32'(bus.busy), 32'h1);
      end
      apply_reset("rst_mid");
    end
    wait_idle(BUSY_CYC, 1'b1, "idle1");

    if (CLR) begin
      model_clear();
      step(1, 0, 3'b010, 32'h3FC, 32'h0, "lw3fc");
      chk("lw3fc.literal", bus.rdata, 32'h0);
      step(1, 0, 3'b010, 32'h14, 32'h0, "lw14_after_drop");
    end else begin
      for (int i = 0; i < DEPTH; i++) step(1, 1, 3'b010, 32'(i * 4), $urandom, "init_sw");
    end

    // Extraction and extension
    step(1, 1, 3'b010, 32'h10, 32'h8899_AABB, "sw10");
    step(1, 0, 3'b000, 32'h13, 32'h0, "lb13");
    chk("lb13.literal", bus.rdata, 32'hFFFF_FF88);
    step(1, 0, 3'b100, 32'h13, 32'h0, "lbu13");
    chk("lbu13.literal", bus.rdata, 32'h0000_0088);
    step(1, 0, 3'b001, 32'h10, 32'h0, "lh10");
    chk("lh10.literal", bus.rdata, 32'hFFFF_AABB);
    step(1, 0, 3'b101, 32'h12, 32'h0, "lhu12");
    chk("lhu12.literal", bus.rdata, 32'h0000_8899);

    // Back-to-back store/store/load on one word
    step(1, 1, 3'b010, 32'h20, 32'h1122_3344, "sw20");
    step(1, 1, 3'b000, 32'h21, 32'h0000_00EE, "sb21");
    step(1, 0, 3'b010, 32'h20, 32'h0, "lw20");
    chk("lw20.literal", bus.rdata, 32'h1122_EE44);
    step(0, 0, 3'b000, 32'h0, 32'h0, "gap");

    // Error cases
    step(1, 1, 3'b010, 32'h30, 32'h0102_0304, "sw30");
    step(1, 0, 3'b010, 32'h22, 32'h0, "lw22_mis");
    chk("lw22.mis_literal", 32'(bus.misalign_err), 32'h1);
    step(1, 1, 3'b001, 32'h31, 32'h0000_BEEF, "sh31_mis");
    step(1, 0, 3'b010, 32'h30, 32'h0, "lw30");
    chk("lw30.literal", bus.rdata, 32'h0102_0304);
    step(1, 0, 3'b010, 32'h400, 32'h0, "lw400_oob");
    chk("lw400.acc_literal", 32'(bus.access_err), 32'h1);
    step(1, 0, 3'b011, 32'h40, 32'h0, "f3_011");
    step(1, 1, 3'b100, 32'h44, 32'h0000_0055, "sb_f3_100");
    step(1, 0, 3'b010, 32'h44, 32'h0, "lw44");
    step(1, 0, 3'b001, 32'h401, 32'h0, "lh401_both");

    // Second reset: requests during busy are dropped; contents cleared or kept.
    apply_reset("rst2");
    wait_idle(BUSY_CYC, 1'b1, "idle2");
    if (CLR) model_clear();
    step(1, 0, 3'b010, 32'h14, 32'h0, "lw14_post_rst");
    step(1, 0, 3'b010, 32'h10, 32'h0, "lw10_post_rst");

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      v  = ($urandom % 5) != 0;
      w  = $urandom % 2;
      f3 = f3_tab[$urandom % 14];
      r  = $urandom % 16;
      if (r == 0) a = 32'(NBYTES) + ($urandom % 256);
      else        a = $urandom % NBYTES;
      if (r < 12) begin
        if (f3 == 3'd1 || f3 == 3'd5) a = a & ~32'h1;
        else if (f3 != 3'd0 && f3 != 3'd4) a = a & ~32'h3;
      end
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) a = a & ~32'h3;
      step(v, w, f3, a, $urandom, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
